// File: rtl/pet_action_scheduler.sv
// Button front-end for the pet FSM: sync, debounce, latch presses, then grant one
// legal action at a time by fixed priority, with a cooldown after each grant.
module pet_action_scheduler #(
  parameter int DEB_CYCLES = 50000,
  parameter int COOLDOWN   = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sleep,
  input  logic btn_awake,
  input  logic btn_feed,
  input  logic btn_play,
  input  logic pet_sleeping,
  input  logic pet_dead,
  output logic act_sleep,
  output logic act_awake,
  output logic act_feed,
  output logic act_play,
  output logic reject,
  output logic busy
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  // Bit positions inside the request vectors
  localparam int B_SLEEP = 0;
  localparam int B_AWAKE = 1;
  localparam int B_FEED  = 2;
  localparam int B_PLAY  = 3;

  typedef enum logic {IDLE, COOL} state_t;

  logic [3:0] btn_raw;
  logic [3:0] rise;

  assign btn_raw = {btn_play, btn_feed, btn_awake, btn_sleep};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          lvl_q, lvl_d;
    logic          prev_q, prev_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
      s1_d   = btn_raw[gi];
      s2_d   = s1_q;
      prev_d = lvl_q;
      lvl_d  = lvl_q;
      cnt_d  = '0;
      if (s2_q != lvl_q) begin
        if (cnt_q == DW'(DEB_CYCLES - 1)) begin
          lvl_d = s2_q;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= s1_d;
        s2_q   <= s2_d;
        lvl_q  <= lvl_d;
        prev_q <= prev_d;
        cnt_q  <= cnt_d;
      end
    end

    assign rise[gi] = lvl_q & ~prev_q;
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    act_q, act_d;
  logic          reject_q, reject_d;
  logic [3:0]    sel;
  logic [3:0]    legal;
  logic [3:0]    clr;

  // One-hot pick of the highest-priority pending request
  always_comb begin
    sel = '0;
    if (pending_q[B_AWAKE])      sel[B_AWAKE] = 1'b1;
    else if (pending_q[B_SLEEP]) sel[B_SLEEP] = 1'b1;
    else if (pending_q[B_FEED])  sel[B_FEED]  = 1'b1;
    else if (pending_q[B_PLAY])  sel[B_PLAY]  = 1'b1;
  end

  always_comb begin
    legal          = '0;
    legal[B_SLEEP] = ~pet_sleeping & ~pet_dead;
    legal[B_AWAKE] =  pet_sleeping & ~pet_dead;
    legal[B_FEED]  = ~pet_sleeping & ~pet_dead;
    legal[B_PLAY]  = ~pet_sleeping & ~pet_dead;
  end

  always_comb begin
    state_d  = state_q;
    cool_d   = cool_q;
    act_d    = '0;
    reject_d = 1'b0;
    clr      = '0;
    case (state_q)
      IDLE: begin
        if (!pet_dead && (pending_q != '0)) begin
          clr = sel;
          if ((sel & legal) != '0) begin
            act_d   = sel;
            cool_d  = CW'(COOLDOWN - 1);
            state_d = COOL;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      COOL: begin
        if (cool_q == '0) begin
          state_d = IDLE;
        end else begin
          cool_d = cool_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A new press in the same cycle as its grant stays pending
    pending_d = pet_dead ? 4'b0000 : ((pending_q & ~clr) | rise);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cool_q    <= '0;
      pending_q <= '0;
      act_q     <= '0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cool_q    <= cool_d;
      pending_q <= pending_d;
      act_q     <= act_d;
      reject_q  <= reject_d;
    end
  end

  assign act_sleep = act_q[B_SLEEP];
  assign act_awake = act_q[B_AWAKE];
  assign act_feed  = act_q[B_FEED];
  assign act_play  = act_q[B_PLAY];
  assign reject    = reject_q;
  assign busy      = (state_q == COOL);

endmodule

// File: tb/tb_pet_action_scheduler.sv
// Bench for pet_action_scheduler: directed scenarios plus random button traffic,
// compared every cycle against a behavioural model of the scheduling rules.
module tb_pet_action_scheduler;
  localparam int DEB = 4;
  localparam int CD  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_sleep = 1'b0, btn_awake = 1'b0, btn_feed = 1'b0, btn_play = 1'b0;
  logic pet_sleeping = 1'b0, pet_dead = 1'b0;
  logic act_sleep, act_awake, act_feed, act_play, reject, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pet_action_scheduler #(.DEB_CYCLES(DEB), .COOLDOWN(CD)) dut (
    .clk(clk), .rst(rst),
    .btn_sleep(btn_sleep), .btn_awake(btn_awake), .btn_feed(btn_feed), .btn_play(btn_play),
    .pet_sleeping(pet_sleeping), .pet_dead(pet_dead),
    .act_sleep(act_sleep), .act_awake(act_awake), .act_feed(act_feed), .act_play(act_play),
    .reject(reject), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural model: raw level seen two edges late, a run-length debounce,
  // a request bitmask and a remaining-cooldown count (0 = free to grant).
  logic [3:0] m_s1, m_s2, m_deb, m_prev, m_pend, e_act;
  logic       e_rej;
  int         m_run [4];
  int         m_cool;

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0; m_pend = '0;
    e_act = '0; e_rej = 1'b0; m_cool = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [3:0] raw, rise, clr, old_deb;
    int idx;
    bit legal;
    raw = {btn_play, btn_feed, btn_awake, btn_sleep};
    rise = m_deb & ~m_prev;
    old_deb = m_deb;
    clr = '0; e_act = '0; e_rej = 1'b0;
    if (m_cool == 0) begin
      if (!pet_dead && m_pend != 0) begin
        if (m_pend[1]) idx = 1;
        else if (m_pend[0]) idx = 0;
        else if (m_pend[2]) idx = 2;
        else idx = 3;
        clr[idx] = 1'b1;
        legal = (idx == 1) ? pet_sleeping : !pet_sleeping;
        if (legal) begin
          e_act[idx] = 1'b1;
          m_cool = CD;
        end else begin
          e_rej = 1'b1;
        end
      end
    end else begin
      m_cool--;
    end
    m_pend = pet_dead ? 4'b0 : ((m_pend & ~clr) | rise);
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        if (m_run[i] == DEB - 1) begin
          m_deb[i] = m_s2[i];
          m_run[i] = 0;
        end else begin
          m_run[i]++;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_prev = old_deb;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_eq("outs", {26'b0, act_play, act_feed, act_awake, act_sleep, reject, busy},
             {26'b0, e_act, e_rej, (m_cool > 0)});
    if ({act_play, act_feed, act_awake, act_sleep, reject} != 5'b0)
      $display("[%0d] act(p,f,a,s)=%b%b%b%b reject=%b busy=%b", cyc,
               act_play, act_feed, act_awake, act_sleep, reject, busy);
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock
  task automatic do_reset(input int hold);
    {btn_sleep, btn_awake, btn_feed, btn_play} = 4'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_async", {26'b0, act_play, act_feed, act_awake, act_sleep, reject, busy}, 32'd0);
    m_reset();
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int first, first2, cnt, cnt2, bn, bfall;
    logic prev_busy;
    #2;
    do_reset(3);

    // Clean feed
    btn_feed = 1'b1; first = -1; cnt = 0; bn = 0;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      if (act_feed) begin cnt++; if (first < 0) first = e; end
      if (busy) bn++;
      if (e == 20) btn_feed = 1'b0;
    end
    check_eq("feed_latency", first, 8);
    check_eq("feed_count", cnt, 1);
    check_eq("feed_busy_len", bn, CD);

    // Bounce then hold
    cnt = 0; first = -1;
    for (int t = 0; t < 20; t++) begin
      btn_sleep = ((t / 2) % 2) == 0;
      cycle();
      if (act_sleep) cnt++;
    end
    btn_sleep = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      if (act_sleep) begin cnt++; if (first < 0) first = e; end
      if (e == 25) btn_sleep = 1'b0;
    end
    check_eq("bounce_latency", first, 8);
    check_eq("bounce_count", cnt, 1);

    // Illegal request while sleeping
    pet_sleeping = 1'b1; btn_play = 1'b1; cnt = 0; cnt2 = 0; bn = 0;
    for (int e = 1; e <= 30; e++) begin
      cycle();
      if (reject) cnt++;
      if ({act_play, act_feed, act_awake, act_sleep} != 4'b0) cnt2++;
      if (busy) bn++;
      if (e == 15) btn_play = 1'b0;
    end
    check_eq("illegal_rejects", cnt, 1);
    check_eq("illegal_acts", cnt2, 0);
    check_eq("illegal_busy", bn, 0);
    pet_sleeping = 1'b0;
    repeat (10) cycle();

    // Simultaneous feed + play
    btn_feed = 1'b1; btn_play = 1'b1; first = -1; first2 = -1; bfall = -1; prev_busy = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      if (act_feed && first < 0) first = e;
      if (act_play && first2 < 0) first2 = e;
      if (prev_busy && !busy && bfall < 0) bfall = e;
      prev_busy = busy;
      if (e == 25) {btn_feed, btn_play} = 2'b00;
    end
    check_eq("simul_feed", first, 8);
    check_eq("simul_busy_fall", bfall, 16);
    check_eq("simul_play", first2, 17);
    repeat (10) cycle();

    // Death blocks everything; recovery afterwards
    pet_dead = 1'b1; {btn_sleep, btn_awake, btn_feed, btn_play} = 4'hF; cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      if ({act_play, act_feed, act_awake, act_sleep, reject} != 5'b0) cnt++;
      if (e == 20) {btn_sleep, btn_awake, btn_feed, btn_play} = 4'h0;
    end
    check_eq("dead_pulses", cnt, 0);
    pet_dead = 1'b0; btn_sleep = 1'b1; first = -1;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      if (act_sleep && first < 0) first = e;
    end
    btn_sleep = 1'b0;
    check_eq("revive_sleep", first, 8);
    repeat (15) cycle();

    // Reset mid-cooldown with feed still pending
    btn_sleep = 1'b1; btn_feed = 1'b1; first = -1;
    for (int e = 1; e <= 11; e++) begin
      cycle();
      if (act_sleep && first < 0) first = e;
    end
    check_eq("midcool_grant", first, 8);
    check_eq("midcool_busy", busy, 1);
    do_reset(2);
    cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      if ({act_play, act_feed, act_awake, act_sleep, reject} != 5'b0) cnt++;
    end
    check_eq("after_reset_pulses", cnt, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(2);
      end else begin
        if ($urandom_range(0, 5) == 0) btn_sleep = ~btn_sleep;
        if ($urandom_range(0, 5) == 0) btn_awake = ~btn_awake;
        if ($urandom_range(0, 5) == 0) btn_feed  = ~btn_feed;
        if ($urandom_range(0, 5) == 0) btn_play  = ~btn_play;
        if ($urandom_range(0, 39) == 0) pet_sleeping = ~pet_sleeping;
        if (pet_dead) begin
          if ($urandom_range(0, 7) == 0) pet_dead = 1'b0;
        end else if ($urandom_range(0, 149) == 0) begin
          pet_dead = 1'b1;
        end
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
